// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: round-robin arbiter sharing one registered W-bit adder between N requesters
module shared_adder_arbiter #(
    parameter int W   = 4,
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic             rsp_valid,
    output logic [W:0]       rsp_sum,
    output logic [IDW-1:0]   rsp_id,
    input  logic             rsp_ready,
    output logic             busy
);
    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;
    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [W:0]       r_sum;
    logic [2*N-1:0]   w_rot;
    logic [IDW-1:0]   w_gnt_id;
    logic [N-1:0]     w_grant;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic             w_any;
    logic             w_can_accept;
    logic             w_accept;
    // Rotate requests so bit k is requester ptr+k; scan far-to-near so the nearest valid one wins
    always_comb begin
        w_rot    = {req_valid, req_valid} >> r_ptr;
        w_any    = 1'b0;
        w_gnt_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any    = 1'b1;
                w_gnt_id = IDW'((int'(r_ptr) + k) % N);
            end
        end
    end
    // Operand mux for the granted requester
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt_id == IDW'(k)) begin
                w_a = req_a[k*W +: W];
                w_b = req_b[k*W +: W];
            end
        end
    end
    // Accept whenever the slot is free or being drained this cycle
    always_comb begin
        w_can_accept = (r_state == S_EMPTY) | rsp_ready;
        w_accept     = w_any & w_can_accept;
        w_grant      = w_any ? (N'(1) << w_gnt_id) : '0;
    end
    // Slot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_next;
    end
    // Next state: an accept always fills the slot; a full slot only empties when drained
    always_comb begin
        w_next = w_accept ? S_FULL : ((r_state == S_FULL) && !rsp_ready) ? S_FULL : S_EMPTY;
    end
    // Outputs; req_ready is gated by rst_n so nothing is handshaken while in reset
    always_comb begin
        rsp_valid = (r_state == S_FULL);
        busy      = (r_state == S_FULL);
        rsp_sum   = r_sum;
        rsp_id    = r_id;
        req_ready = w_grant & {N{w_can_accept & rst_n}};
    end
    // Result slot and round-robin pointer advance only on an accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_accept) begin
            r_sum <= {1'b0, w_a} + {1'b0, w_b};
            r_id  <= w_gnt_id;
            r_ptr <= (w_gnt_id == IDW'(N - 1)) ? '0 : w_gnt_id + 1'b1;
        end
    end
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb_shared_adder_arbiter: directed stimulus with a cycle-level reference model and literal checks
module tb_shared_adder_arbiter;
    localparam int W   = 4;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic [W:0]       rsp_sum;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_ready = 1'b0;
    logic             busy;

    int n_chk = 0;
    int n_fail = 0;

    bit m_valid = 1'b0;
    int m_sum = 0;
    int m_id = 0;
    int m_ptr = 0;
    int mg;
    int exp_ready;

    shared_adder_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    always_comb begin
        mg = pick(req_valid, m_ptr);
        exp_ready = (rst_n && mg >= 0 && (!m_valid || rsp_ready)) ? (1 << mg) : 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_sum   <= 0;
            m_id    <= 0;
            m_ptr   <= 0;
        end else if (mg >= 0 && (!m_valid || rsp_ready)) begin
            m_valid <= 1'b1;
            m_sum   <= int'(req_a[mg*W +: W]) + int'(req_b[mg*W +: W]);
            m_id    <= mg;
            m_ptr   <= (mg + 1) % N;
        end else if (m_valid && rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("model_req_ready", int'(req_ready), exp_ready);
        chk("model_rsp_valid", int'(rsp_valid), int'(m_valid));
        chk("model_busy", int'(busy), int'(m_valid));
        chk("model_rsp_sum", int'(rsp_sum), m_sum);
        chk("model_rsp_id", int'(rsp_id), m_id);
    end

    initial begin
        int ids[5] = '{1, 2, 3, 0, 1};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        // single request
        #1 rst_n = 1'b1; req_valid = 4'b0001; set_ops(0, 9, 8); rsp_ready = 1'b1;
        #1 chk("t1_req_ready", int'(req_ready), 1);
        @(negedge clk);
        chk("t1_rsp_valid", int'(rsp_valid), 1);
        chk("t1_rsp_sum", int'(rsp_sum), 17);
        chk("t1_rsp_id", int'(rsp_id), 0);
        // round robin with all valid
        #1 req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_ops(i, i + 1, i + 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_rsp_id", int'(rsp_id), ids[k]);
            chk("t2_rsp_sum", int'(rsp_sum), 2 * (ids[k] + 1));
        end
        // backpressure
        #1 rsp_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t3_req_ready", int'(req_ready), 0);
            chk("t3_hold_sum", int'(rsp_sum), 4);
            chk("t3_hold_id", int'(rsp_id), 1);
        end
        #1 rsp_ready = 1'b1;
        #1 chk("t3_next_grant", int'(req_ready), 4'b0100);
        @(negedge clk);
        chk("t3_rsp_id", int'(rsp_id), 2);
        chk("t3_rsp_sum", int'(rsp_sum), 6);
        // max operands on requester 3, then pointer wraps to 0
        #1 req_valid = 4'b1000; set_ops(3, 15, 15);
        @(negedge clk);
        chk("t4_rsp_sum", int'(rsp_sum), 30);
        chk("t4_rsp_id", int'(rsp_id), 3);
        #1 req_valid = 4'b1111;
        #1 chk("t4_wrap_grant", int'(req_ready), 4'b0001);
        // skip idle requesters
        #1 req_valid = 4'b0100;
        #1 chk("t5_grant2", int'(req_ready), 4'b0100);
        @(negedge clk);
        chk("t5_rsp_id", int'(rsp_id), 2);
        #1 req_valid = 4'b0011;
        #1 chk("t5_grant0", int'(req_ready), 4'b0001);
        @(negedge clk);
        chk("t5_rsp_id0", int'(rsp_id), 0);
        #1 chk("t5_grant1", int'(req_ready), 4'b0010);
        @(negedge clk);
        chk("t5_rsp_id1", int'(rsp_id), 1);
        chk("t5_rsp_sum1", int'(rsp_sum), 4);
        // async reset while full and stalled
        #1 rsp_ready = 1'b0; req_valid = 4'b1010;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t6_rsp_valid", int'(rsp_valid), 0);
        chk("t6_rsp_sum", int'(rsp_sum), 0);
        chk("t6_rsp_id", int'(rsp_id), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_req_ready", int'(req_ready), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1; rsp_ready = 1'b1;
        #1 chk("t6_first_grant", int'(req_ready), 4'b0010);
        @(negedge clk);
        chk("t6_rsp_id", int'(rsp_id), 1);
        #1 req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        #1 $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
